draw_arbiter: RTL and testbench
===============================

DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd40000, is the maximum number of DRAW-state cycles to wait for iDrawDone; 0 disables the watchdog.
REQ-002 iClock  input  1  single clock; all state updates on its rising edge.
REQ-003 iReset  input  1  synchronous, active-high reset.
REQ-004 iReq  input  4  per-requester draw/erase request, bit i = requester i; held high until oAck[i].
REQ-005 iErase  input  4  per-requester operation: 1 = clear box, 0 = draw box.
REQ-006 iX  input  32  packed x origins, requester i at [8i+7:8i].
REQ-007 iY  input  28  packed y origins, requester i at [7i+6:7i].
REQ-008 iXDim, iYDim  input  32 each  packed box dimensions, requester i at [8i+7:8i].
REQ-009 iColour  input  24  packed colours, requester i at [6i+5:6i].
REQ-010 iDrawDone  input  1  completion pulse from the shared box-drawing engine.
REQ-011 oGo, oErase  output  1 each  engine start/mode; oGo is held high for the whole operation.
REQ-012 oX[7:0], oY[6:0], oXDim[7:0], oYDim[7:0], oColour[5:0]  output  latched operands for the engine.
REQ-013 oGrant  output  4  one-hot; identifies the requester being serviced (LOAD, DRAW and ACK states).
REQ-014 oAck  output  4  one-cycle completion pulse to the serviced requester.
REQ-015 oBusy  output  1  high in every state except IDLE.
REQ-016 oTimeout  output  1  sticky watchdog flag.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, DRAW and ACK.
REQ-018 IDLE SHALL move to LOAD on the first edge at which |iReq=1; otherwise it SHALL stay in IDLE.
REQ-019 On IDLE->LOAD the winner SHALL be chosen round-robin, scanning from index ptr to ptr+3 mod 4, and registered.
REQ-020 In LOAD, oGrant SHALL equal the winner, and the winner's operands and iErase bit SHALL be latched into oX..oColour/oErase on exit.
REQ-021 LOAD SHALL always last exactly one cycle, then move to DRAW.
REQ-022 In DRAW, oGo=1 and the operand outputs SHALL stay stable.
REQ-023 In DRAW, input changes SHALL NOT affect the operand outputs or the winner, including deassertion of the winner's iReq.
REQ-024 DRAW SHALL move to ACK on the edge where iDrawDone=1; iDrawDone outside DRAW SHALL be ignored.
REQ-025 In ACK, oAck[winner]=1 and oGo=0, and ptr SHALL update to (winner+1) mod 4.
REQ-026 ACK SHALL always last exactly one cycle, then return to IDLE.
REQ-027 Latency: a request seen in IDLE at cycle k SHALL give oGrant in cycle k+1, oGo in k+2, and oAck in the cycle after iDrawDone is sampled.
REQ-028 A requester whose iReq is still high in the IDLE cycle after its ACK SHALL be eligible again, but behind any other pending requesters.
REQ-029 Watchdog: the counter SHALL clear on entry to DRAW and increment each DRAW cycle.
REQ-030 If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without iDrawDone, the FSM SHALL go to ACK, oAck SHALL still pulse, and oTimeout SHALL set and hold until reset.
REQ-031 If iDrawDone and the watchdog expiry coincide, the draw SHALL be treated as completed and oTimeout SHALL remain unchanged.
REQ-032 oGo, oAck, oGrant and oBusy SHALL be registered or decoded from the state only, and SHALL be glitch-free at the edge.

Reset
REQ-033 iReset=1 at an edge SHALL force IDLE and ptr=0, and SHALL clear oTimeout and the watchdog counter.
REQ-034 iReset=1 SHALL zero all operand outputs, oGo, oErase, oGrant, oAck and oBusy.
REQ-035 Reset SHALL take priority over all other events, including mid-DRAW; no oAck SHALL be issued for an aborted operation.
REQ-036 After reset release, requester 0 SHALL have highest priority.

Configuration
REQ-037 Macro DRAW_ARBITER_CLEAR_PRIORITY_EN, when defined, SHALL make any pending request with iErase=1 beat all requests with iErase=0 in IDLE; round-robin order SHALL apply within each class.
REQ-038 When DRAW_ARBITER_CLEAR_PRIORITY_EN is undefined, pure round-robin SHALL apply regardless of iErase, and the port list SHALL be identical in both builds.

Verification
REQ-039 Reset, then iReq=4'b0001 with iX[7:0]=8'd10 -> oGrant=0001 next cycle; oGo=1 and oX=10 the cycle after; iDrawDone pulse -> oAck=0001 for one cycle, then oBusy=0.
REQ-040 iReq=4'b1111 held, each done after 5 cycles -> service order 0,1,2,3,0, with exactly one oAck bit per service.
REQ-041 iReq[2] dropped mid-DRAW and iX changed -> oX unchanged, and oAck[2] still pulses on iDrawDone.
REQ-042 TIMEOUT_CYCLES=8, iDrawDone never asserted -> oGo high for 8 cycles, then oAck pulses and oTimeout=1 until iReset.
REQ-043 With DRAW_ARBITER_CLEAR_PRIORITY_EN, ptr=0, iReq=4'b0011, iErase=4'b0010 -> requester 1 is granted first, then requester 0.
REQ-044 iReset asserted during DRAW -> next cycle oGo=0, oBusy=0, no oAck; then iReq=4'b1000 -> oGrant=1000.

Source files
------------

// File: rtl/draw_arbiter.sv
// draw_arbiter: round-robin arbiter sharing one box-drawing engine among 4 requesters; DRAW_ARBITER_CLEAR_PRIORITY_EN lets erase requests win first.
// oGrant 1 cycle after a request is seen in IDLE, oGo 1 cycle later; requesters hold iReq until oAck, and a watchdog bounds the wait for iDrawDone.
module draw_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd40000
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [3:0]  iReq,
  input  logic [3:0]  iErase,
  input  logic [31:0] iX,
  input  logic [27:0] iY,
  input  logic [31:0] iXDim,
  input  logic [31:0] iYDim,
  input  logic [23:0] iColour,
  input  logic        iDrawDone,
  output logic        oGo,
  output logic        oErase,
  output logic [7:0]  oX,
  output logic [6:0]  oY,
  output logic [7:0]  oXDim,
  output logic [7:0]  oYDim,
  output logic [5:0]  oColour,
  output logic [3:0]  oGrant,
  output logic [3:0]  oAck,
  output logic        oBusy,
  output logic        oTimeout
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_ACK} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_ptr;
  logic [1:0]  r_winner;
  logic [15:0] r_cnt;
  logic        r_timeout;
  logic        r_erase;
  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [7:0]  r_xdim;
  logic [7:0]  r_ydim;
  logic [5:0]  r_colour;
  logic [3:0]  w_cand;
  logic [1:0]  w_idx;
  logic [1:0]  w_pick;
  logic [3:0]  w_onehot;
  logic        w_wd_hit;
  logic        w_expire;

  // Erase requests form a higher class only in the priority build.
  always_comb begin
    w_cand = iReq;
`ifdef DRAW_ARBITER_CLEAR_PRIORITY_EN
    if (|(iReq & iErase)) w_cand = iReq & iErase;
`endif
  end

  // Scan from the farthest slot to the nearest so the one closest to r_ptr wins.
  always_comb begin
    w_pick = r_ptr;
    w_idx  = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_ptr + 2'(i);
      if (w_cand[w_idx]) w_pick = w_idx;
    end
  end

  assign w_wd_hit = (TIMEOUT_CYCLES != 16'd0) && (r_cnt == TIMEOUT_CYCLES - 16'd1);

  always_comb begin
    w_next   = r_state;
    w_expire = 1'b0;
    case (r_state)
      S_IDLE: if (|iReq) w_next = S_LOAD;
      S_LOAD: w_next = S_DRAW;
      S_DRAW: begin
        if (iDrawDone) begin
          w_next = S_ACK;
        end else if (w_wd_hit) begin
          w_next   = S_ACK;
          w_expire = 1'b1;
        end
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_ptr     <= 2'd0;
      r_winner  <= 2'd0;
      r_cnt     <= 16'd0;
      r_timeout <= 1'b0;
      r_erase   <= 1'b0;
      r_x       <= 8'd0;
      r_y       <= 7'd0;
      r_xdim    <= 8'd0;
      r_ydim    <= 8'd0;
      r_colour  <= 6'd0;
    end else begin
      if (r_state == S_IDLE && |iReq) r_winner <= w_pick;
      if (r_state == S_LOAD) begin
        r_cnt    <= 16'd0;
        r_erase  <= iErase[r_winner];
        r_x      <= iX[8*r_winner +: 8];
        r_y      <= iY[7*r_winner +: 7];
        r_xdim   <= iXDim[8*r_winner +: 8];
        r_ydim   <= iYDim[8*r_winner +: 8];
        r_colour <= iColour[6*r_winner +: 6];
      end else if (r_state == S_DRAW) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_expire) r_timeout <= 1'b1;
      // Just-served requester drops to the back of the rotation.
      if (r_state == S_ACK) r_ptr <= r_winner + 2'd1;
    end
  end

  assign w_onehot = 4'b0001 << r_winner;
  assign oGrant   = (r_state != S_IDLE) ? w_onehot : 4'b0000;
  assign oAck     = (r_state == S_ACK) ? w_onehot : 4'b0000;
  assign oGo      = (r_state == S_DRAW);
  assign oBusy    = (r_state != S_IDLE);
  assign oTimeout = r_timeout;
  assign oErase   = r_erase;
  assign oX       = r_x;
  assign oY       = r_y;
  assign oXDim    = r_xdim;
  assign oYDim    = r_ydim;
  assign oColour  = r_colour;

endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: directed scenarios followed by randomized services, checked against a round-robin reference model.
module tb_draw_arbiter;
  localparam logic [15:0] TO = 16'd8;
`ifdef DRAW_ARBITER_CLEAR_PRIORITY_EN
  localparam bit CLEAR_PRI = 1'b1;
`else
  localparam bit CLEAR_PRI = 1'b0;
`endif

  logic        iClock = 1'b0;
  logic        iReset;
  logic [3:0]  iReq;
  logic [3:0]  iErase;
  logic [31:0] iX;
  logic [27:0] iY;
  logic [31:0] iXDim;
  logic [31:0] iYDim;
  logic [23:0] iColour;
  logic        iDrawDone;
  logic        oGo, oErase, oBusy, oTimeout;
  logic [7:0]  oX, oXDim, oYDim;
  logic [6:0]  oY;
  logic [5:0]  oColour;
  logic [3:0]  oGrant, oAck;

  draw_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .iClock(iClock), .iReset(iReset), .iReq(iReq), .iErase(iErase),
    .iX(iX), .iY(iY), .iXDim(iXDim), .iYDim(iYDim), .iColour(iColour),
    .iDrawDone(iDrawDone), .oGo(oGo), .oErase(oErase), .oX(oX), .oY(oY),
    .oXDim(oXDim), .oYDim(oYDim), .oColour(oColour), .oGrant(oGrant),
    .oAck(oAck), .oBusy(oBusy), .oTimeout(oTimeout)
  );

  always #5 iClock = ~iClock;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  bit m_timeout = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge iClock);
    #1;
  endtask

  // Reference arbitration: nearest pending requester at or after ptr, erase class first when enabled.
  function automatic int pick(input logic [3:0] req, input logic [3:0] er, input int ptr);
    logic [3:0] cand;
    cand = req;
    if (CLEAR_PRI && (req & er) != 4'b0) cand = req & er;
    for (int k = 0; k < 4; k++) if (cand[(ptr + k) % 4]) return (ptr + k) % 4;
    return 0;
  endfunction

  task automatic scramble;
    iX = $urandom; iY = 28'($urandom); iXDim = $urandom;
    iYDim = $urandom; iColour = 24'($urandom);
  endtask

  task automatic do_reset(input string tag);
    iReset = 1'b1; iReq = 4'b0; iErase = 4'b0; iDrawDone = 1'b0;
    tick;
    chk({tag, "/rst_ctl"}, {oGo, oAck, oGrant, oBusy, oTimeout, oErase}, 64'd0);
    chk({tag, "/rst_ops"}, {oX, oY, oXDim, oYDim, oColour}, 64'd0);
    tick;
    iReset = 1'b0;
    m_ptr = 0;
    m_timeout = 1'b0;
  endtask

  // One full service from IDLE; d = DRAW cycle carrying iDrawDone (0 = never).
  task automatic serve(input string tag, input int w, input int d, input bit spurious,
                       input bit drop_mid, input bit drop_after);
    logic [3:0]  oh;
    logic [37:0] eops;
    int          c;
    bit          fin;
    oh = 4'b0001 << w;
    tick;
    chk({tag, "/load_grant"}, oGrant, oh);
    chk({tag, "/load_ctl"}, {oGo, oAck, oBusy}, {1'b0, 4'b0, 1'b1});
    eops = {iErase[w], iX[8*w +: 8], iY[7*w +: 7], iXDim[8*w +: 8], iYDim[8*w +: 8], iColour[6*w +: 6]};
    iDrawDone = spurious;
    tick;
    iDrawDone = 1'b0;
    c = 0;
    fin = 1'b0;
    while (!fin) begin
      c++;
      chk({tag, "/draw_ctl"}, {oGo, oAck, oGrant, oBusy}, {1'b1, 4'b0, oh, 1'b1});
      chk({tag, "/draw_ops"}, {oErase, oX, oY, oXDim, oYDim, oColour}, eops);
      if (c == 1) begin
        scramble;
        iErase = 4'($urandom);
        if (drop_mid) iReq[w] = 1'b0;
      end
      iDrawDone = (c == d);
      tick;
      iDrawDone = 1'b0;
      if (c == d) fin = 1'b1;
      else if (c == int'(TO)) begin
        fin = 1'b1;
        m_timeout = 1'b1;
      end
    end
    chk({tag, "/ack"}, {oAck, oGo, oGrant, oBusy}, {oh, 1'b0, oh, 1'b1});
    chk({tag, "/ack_tmo"}, oTimeout, m_timeout);
    m_ptr = (w + 1) % 4;
    if (drop_after) iReq[w] = 1'b0;
    tick;
    chk({tag, "/idle"}, {oGo, oAck, oGrant, oBusy, oTimeout}, {1'b0, 4'b0, 4'b0, 1'b0, m_timeout});
  endtask

  initial begin
    int w;
    iReset = 1'b1; iReq = 4'b0; iErase = 4'b0; iDrawDone = 1'b0;
    iX = 32'b0; iY = 28'b0; iXDim = 32'b0; iYDim = 32'b0; iColour = 24'b0;

    // Single request, basic latency and operand capture.
    do_reset("r0");
    scramble;
    iX[7:0] = 8'd10;
    iReq = 4'b0001;
    serve("basic", 0, 3, 1'b0, 1'b0, 1'b1);
    tick;
    chk("basic/stay_idle", {oBusy, oGrant}, 64'd0);

    // Erase class priority (pure round-robin in the default build).
    do_reset("r1");
    scramble;
    iReq = 4'b0011;
    iErase = 4'b0010;
    serve("clrpri_a", CLEAR_PRI ? 1 : 0, 2, 1'b0, 1'b0, 1'b1);
    iErase = 4'b0010;
    serve("clrpri_b", CLEAR_PRI ? 0 : 1, 2, 1'b0, 1'b0, 1'b1);

    // All four held: rotation 0,1,2,3,0.
    do_reset("r2");
    iReq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      iErase = 4'b0;
      serve("rr", k % 4, 5, k == 2, 1'b0, 1'b0);
    end

    // Done coinciding with watchdog expiry counts as completion.
    iReq = 4'b0010; iErase = 4'b0;
    serve("coincide", 1, int'(TO), 1'b0, 1'b0, 1'b1);

    // Watchdog expiry: oAck still pulses, oTimeout sticks.
    iReq = 4'b0100; iErase = 4'b0;
    serve("timeout", 2, 0, 1'b0, 1'b0, 1'b1);

    // Requester drops iReq mid-DRAW while operands change.
    iReq = 4'b0100;
    serve("dropmid", 2, 4, 1'b0, 1'b1, 1'b1);

    // Reset mid-DRAW aborts without oAck and restores requester-0 priority.
    iReq = 4'b0001;
    tick;
    tick;
    tick;
    chk("abort/in_draw", oGo, 1'b1);
    do_reset("abort");
    iReq = 4'b1000;
    serve("after_abort", 3, 2, 1'b0, 1'b0, 1'b1);

    // Randomized services against the reference model.
    for (int n = 0; n < 40; n++) begin
      iReq = iReq | 4'($urandom);
      if (iReq == 4'b0) iReq = 4'b0001;
      iErase = 4'($urandom);
      scramble;
      w = pick(iReq, iErase, m_ptr);
      serve("rand", w, $urandom_range(0, 9), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end
endmodule
